// File: rtl/dcache_miss_controller_pkg.sv
// Shared types and address helpers for the data-cache miss controller.
package dcache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REFILL_REQ  = 3'd1,
        REFILL_WAIT = 3'd2,
        WRITE_THRU  = 3'd3,
        REPLAY      = 3'd4
    } dcache_state_t;

    // Byte-within-word offset of a 32-bit word.
    localparam int unsigned WORD_BYTE_W = 2;

    function automatic int unsigned line_offset_w(input int unsigned words_per_line);
        return $clog2(words_per_line) + WORD_BYTE_W;
    endfunction

    function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned off_w);
        return addr & ~((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_miss_controller_refill_counter.sv
// Word-in-line counter for cache refills; wraps naturally after the last word.
module refill_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    // Line size is a power of two, so the last index is all ones.
    assign last = &count;

endmodule

// File: rtl/dcache_miss_controller.sv
// Memory-stage data-cache sequencer: load-miss line refill, store write-through,
// and a one-cycle replay that lets the held access complete.
module dcache_miss_controller
    import dcache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_IDX_WIDTH = $clog2(WORDS_PER_LINE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      hit,
    output logic                      stall,
    output logic                      mem_rd_req,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    input  logic                      mem_rd_valid,
    output logic                      refill_we,
    output logic [WORD_IDX_WIDTH-1:0] refill_word,
    output logic                      refill_tag_we,
    output logic                      mem_wr_req,
    input  logic                      mem_wr_ack
);

    localparam int unsigned OFF_W = line_offset_w(WORDS_PER_LINE);

    dcache_state_t             state;
    logic [ADDR_WIDTH-1:0]     line_addr;
    logic [WORD_IDX_WIDTH-1:0] cnt;
    logic                      cnt_last;
    logic                      cnt_clr;
    logic                      cnt_en;
    logic                      load_miss;
    logic                      store;

    assign load_miss = req_valid & ~req_write & ~hit;
    assign store     = req_valid & req_write;
    assign cnt_clr   = (state == REFILL_REQ);
    assign cnt_en    = (state == REFILL_WAIT) & mem_rd_valid;

    refill_counter #(
        .WIDTH (WORD_IDX_WIDTH)
    ) u_refill_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            line_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        line_addr <= ADDR_WIDTH'(line_align(64'(req_addr), OFF_W));
                        state     <= REFILL_REQ;
                    end else if (store) begin
                        state <= WRITE_THRU;
                    end
                end
                REFILL_REQ:  state <= REFILL_WAIT;
                REFILL_WAIT: if (mem_rd_valid && cnt_last) state <= REPLAY;
                WRITE_THRU:  if (mem_wr_ack) state <= REPLAY;
                REPLAY:      state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so an aborted refill never writes a tag.
    always_comb begin
        stall         = 1'b0;
        mem_rd_req    = 1'b0;
        mem_rd_addr   = '0;
        refill_we     = 1'b0;
        refill_word   = '0;
        refill_tag_we = 1'b0;
        mem_wr_req    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: stall = load_miss | store;
                REFILL_REQ: begin
                    stall       = 1'b1;
                    mem_rd_req  = 1'b1;
                    mem_rd_addr = line_addr;
                end
                REFILL_WAIT: begin
                    stall         = 1'b1;
                    mem_rd_addr   = line_addr;
                    refill_we     = mem_rd_valid;
                    refill_word   = mem_rd_valid ? cnt : '0;
                    refill_tag_we = mem_rd_valid & cnt_last;
                end
                WRITE_THRU: begin
                    stall      = 1'b1;
                    mem_wr_req = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Transaction-level bench: each access type has an expected cycle timeline derived from its rules.
module tb_dcache_miss_controller;

    localparam int AW  = 32;
    localparam int WPL = 4;
    localparam int WIW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_write, hit;
    logic [AW-1:0]  req_addr;
    logic           stall, mem_rd_req, refill_we, refill_tag_we, mem_wr_req;
    logic [AW-1:0]  mem_rd_addr;
    logic [WIW-1:0] refill_word;
    logic           mem_rd_valid, mem_wr_ack;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    dcache_miss_controller #(
        .ADDR_WIDTH     (AW),
        .WORDS_PER_LINE (WPL),
        .WORD_IDX_WIDTH (WIW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .hit           (hit),
        .stall         (stall),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_valid  (mem_rd_valid),
        .refill_we     (refill_we),
        .refill_word   (refill_word),
        .refill_tag_we (refill_tag_we),
        .mem_wr_req    (mem_wr_req),
        .mem_wr_ack    (mem_wr_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+2.
    task automatic expect_out(input string tag, input logic s, input logic rr, input logic [AW-1:0] ra,
                              input logic we, input logic [WIW-1:0] wd, input logic twe, input logic wr);
        #1;
        chk({tag, ".stall"},         stall,         s);
        chk({tag, ".mem_rd_req"},    mem_rd_req,    rr);
        chk({tag, ".mem_rd_addr"},   mem_rd_addr,   ra);
        chk({tag, ".refill_we"},     refill_we,     we);
        chk({tag, ".refill_word"},   refill_word,   wd);
        chk({tag, ".refill_tag_we"}, refill_tag_we, twe);
        chk({tag, ".mem_wr_req"},    mem_wr_req,    wr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid = 0; req_write = 0; hit = 0; req_addr = '0;
        mem_rd_valid = 0; mem_wr_ack = 0;
    endtask

    // Request-side inputs are don't-care outside IDLE, so scramble them.
    task automatic scramble_req();
        req_valid = 1'($urandom); req_write = 1'($urandom); hit = 1'($urandom);
        req_addr  = $urandom;
    endtask

    task automatic load_hit(input string tag, input logic [AW-1:0] addr);
        req_valid = 1; req_write = 0; hit = 1; req_addr = addr;
        mem_rd_valid = 1'($urandom); mem_wr_ack = 1'($urandom);
        expect_out({tag, ".hit"}, 0, 0, '0, 0, '0, 0, 0);
        tick();
        quiet();
        expect_out({tag, ".after"}, 0, 0, '0, 0, '0, 0, 0);
        tick();
    endtask

    task automatic load_miss(input string tag, input logic [AW-1:0] addr, input int gaps[WPL]);
        logic [AW-1:0] line;
        line = (addr / (WPL * 4)) * (WPL * 4);
        req_valid = 1; req_write = 0; hit = 0; req_addr = addr;
        mem_rd_valid = 1'($urandom); mem_wr_ack = 1'($urandom);
        expect_out({tag, ".trig"}, 1, 0, '0, 0, '0, 0, 0);
        tick();
        scramble_req(); mem_rd_valid = 0; mem_wr_ack = 1'($urandom);
        expect_out({tag, ".req"}, 1, 1, line, 0, '0, 0, 0);
        tick();
        for (int w = 0; w < WPL; w++) begin
            for (int g = 0; g < gaps[w]; g++) begin
                scramble_req(); mem_rd_valid = 0; mem_wr_ack = 1'($urandom);
                expect_out($sformatf("%s.gap%0d", tag, w), 1, 0, line, 0, '0, 0, 0);
                tick();
            end
            scramble_req(); mem_rd_valid = 1; mem_wr_ack = 1'($urandom);
            expect_out($sformatf("%s.word%0d", tag, w), 1, 0, line, 1, WIW'(w), (w == WPL - 1), 0);
            tick();
        end
        req_valid = 1; req_write = 1'($urandom); hit = 0; mem_rd_valid = 1; mem_wr_ack = 1;
        expect_out({tag, ".replay"}, 0, 0, '0, 0, '0, 0, 0);
        tick();
        quiet();
    endtask

    task automatic store(input string tag, input logic [AW-1:0] addr, input logic hit_in, input int d);
        req_valid = 1; req_write = 1; hit = hit_in; req_addr = addr;
        mem_rd_valid = 1'($urandom); mem_wr_ack = 1'($urandom);
        expect_out({tag, ".trig"}, 1, 0, '0, 0, '0, 0, 0);
        tick();
        for (int i = 1; i <= d; i++) begin
            scramble_req(); mem_rd_valid = 1'($urandom); mem_wr_ack = (i == d);
            expect_out($sformatf("%s.wt%0d", tag, i), 1, 0, '0, 0, '0, 0, 1);
            tick();
        end
        req_valid = 1; req_write = 1; hit = 1'($urandom); mem_rd_valid = 1; mem_wr_ack = 1;
        expect_out({tag, ".replay"}, 0, 0, '0, 0, '0, 0, 0);
        tick();
        quiet();
    endtask

    initial begin
        int gp[WPL];
        quiet();
        rst = 1;
        expect_out("rst0", 0, 0, '0, 0, '0, 0, 0);
        tick();
        expect_out("rst1", 0, 0, '0, 0, '0, 0, 0);
        tick();
        rst = 0;
        expect_out("idle0", 0, 0, '0, 0, '0, 0, 0);
        tick();

        load_hit("hit100", 32'h100);

        gp = '{1, 0, 2, 0};
        load_miss("miss1234", 32'h1234, gp);

        store("st40", 32'h40, 1'b1, 3);

        // Spurious memory responses while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            quiet(); mem_rd_valid = 1; mem_wr_ack = 1; req_addr = $urandom;
            expect_out($sformatf("spur%0d", i), 0, 0, '0, 0, '0, 0, 0);
            tick();
        end
        quiet();

        // Reset after two of four refill words aborts without a tag write.
        req_valid = 1; req_write = 0; hit = 0; req_addr = 32'h3008;
        expect_out("abort.trig", 1, 0, '0, 0, '0, 0, 0);
        tick();
        quiet();
        expect_out("abort.req", 1, 1, 32'h3000, 0, '0, 0, 0);
        tick();
        for (int w = 0; w < 2; w++) begin
            mem_rd_valid = 1;
            expect_out($sformatf("abort.word%0d", w), 1, 0, 32'h3000, 1, WIW'(w), 0, 0);
            tick();
        end
        rst = 1; mem_rd_valid = 1;
        expect_out("abort.rst", 0, 0, '0, 0, '0, 0, 0);
        tick();
        rst = 0; mem_rd_valid = 1; mem_wr_ack = 1;
        expect_out("abort.idle", 0, 0, '0, 0, '0, 0, 0);
        tick();
        quiet();

        gp = '{0, 0, 0, 0};
        load_miss("miss1000", 32'h1000, gp);
        load_miss("miss2000", 32'h2000, gp);

        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: load_hit($sformatf("r%0d.hit", t), $urandom);
                1: begin
                    for (int w = 0; w < WPL; w++) gp[w] = $urandom_range(0, 3);
                    load_miss($sformatf("r%0d.miss", t), $urandom, gp);
                end
                2: store($sformatf("r%0d.st", t), $urandom, 1'($urandom), $urandom_range(1, 4));
                default: begin
                    quiet(); mem_rd_valid = 1'($urandom); mem_wr_ack = 1'($urandom);
                    req_valid = 1'($urandom); req_write = 0; hit = 1;
                    expect_out($sformatf("r%0d.idle", t), 0, 0, '0, 0, '0, 0, 0);
                    tick();
                    quiet();
                end
            endcase
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dcache_miss_controller.md
Name: dcache_miss_controller

Overview:
- FSM that sequences the data cache in the memory stage of the pipelined RV32I core.
- On a load miss, stalls the pipeline and refills one cache line word-by-word from main memory.
- On a store, holds the pipeline until the write-through to main memory is acknowledged.
- After either event, releases the stall for one replay cycle so the stalled access completes against the updated cache.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORDS_PER_LINE, 4, 32-bit words per cache line; must be a power of two, at least 2.
- WORD_IDX_WIDTH, $clog2(WORDS_PER_LINE), width of the word-in-line index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load or store present in memory stage.
- req_write  in  1  1 = store, 0 = load; qualified by req_valid.
- req_addr  in  ADDR_WIDTH  byte address of the access.
- hit  in  1  combinational tag+valid match from cache arrays for req_addr.
- stall  out  1  freezes PC and fetch/decode/execute/memory pipeline registers.
- mem_rd_req  out  1  one-cycle pulse requesting a line read.
- mem_rd_addr  out  ADDR_WIDTH  line-aligned address; low log2(WORDS_PER_LINE)+2 bits are zero.
- mem_rd_valid  in  1  one returned word per pulse, in ascending word order.
- refill_we  out  1  write returned word into cache data array.
- refill_word  out  WORD_IDX_WIDTH  word index for refill_we.
- refill_tag_we  out  1  write tag and set valid; asserted with the last refill_we.
- mem_wr_req  out  1  write-through request; held high until acknowledged.
- mem_wr_ack  in  1  main memory accepted the store.

Behaviour:
- States: IDLE, REFILL_REQ, REFILL_WAIT, WRITE_THRU, REPLAY. State encoding is held in the package.
- Reset: state=IDLE, word counter=0, latched line address=0. All outputs are 0 in the reset cycle and in IDLE when there is no trigger. Reset in any state aborts the operation and returns to IDLE on the next edge; no partial tag write occurs.
- Triggers (IDLE only): load_miss = req_valid & ~req_write & ~hit; store = req_valid & req_write.
- IDLE:
  - stall = load_miss | store (combinational, same cycle).
  - On load_miss: latch line-aligned req_addr, go to REFILL_REQ.
  - On store: go to WRITE_THRU.
  - A load hit causes no stall and no state change.
  - mem_rd_valid and mem_wr_ack are ignored.
- REFILL_REQ:
  - stall=1, mem_rd_req=1 for exactly this cycle, mem_rd_addr=latched address.
  - Word counter cleared to 0. Go to REFILL_WAIT.
- REFILL_WAIT:
  - stall=1.
  - Each cycle with mem_rd_valid=1: refill_we=1, refill_word=counter, counter increments.
  - When counter=WORDS_PER_LINE-1: refill_tag_we=1 in the same cycle, counter wraps to 0, go to REPLAY.
  - No timeout; gaps between mem_rd_valid pulses of any length are legal.
- WRITE_THRU:
  - stall=1, mem_wr_req=1.
  - On mem_wr_ack=1, go to REPLAY. An ack in the first WRITE_THRU cycle is legal (minimum store stall = 1 cycle beyond the trigger cycle).
  - Store policy: no-write-allocate. On a store hit the datapath updates the cache array; the controller does not refill on a store.
- REPLAY:
  - stall=0 and no trigger evaluation for this single cycle; the held instruction advances.
  - Always returns to IDLE.
- Request inputs are not re-sampled outside IDLE. mem_rd_addr stays stable from REFILL_REQ through the end of REFILL_WAIT.
- Latency:
  - Load-miss stall = 1 (trigger) + 1 (REFILL_REQ) + cycles until the last mem_rd_valid.
  - Store stall = 1 + cycles until mem_wr_ack.
- mem_rd_req and mem_wr_req are never both high. refill_we is high only in REFILL_WAIT.

Decomposition:
- Package dcache_ctrl_pkg: state enum typedef (dcache_state_t), line offset width constant, line-align helper function.
- One sub-module is natural: refill_counter, a WORD_IDX_WIDTH up-counter with clear, enable and a last-word flag. It is instantiated once.

Test Plan:
- Load hit, req_addr=0x100, hit=1 -> stall=0 throughout; mem_rd_req never asserted; state stays IDLE.
- Load miss, req_addr=0x1234, WORDS_PER_LINE=4, mem_rd_valid on cycles +3,+4,+7,+8:
  - mem_rd_req one pulse with mem_rd_addr=0x1230.
  - refill_word sequence 0,1,2,3; refill_tag_we only with word 3.
  - stall high from the trigger cycle through the last word; stall low for exactly one REPLAY cycle.
- Store, req_addr=0x40, mem_wr_ack 3 cycles after the trigger -> mem_wr_req high for 3 cycles, stall drops in the REPLAY cycle, no refill activity.
- rst asserted after 2 of 4 refill words -> next cycle state=IDLE, all outputs 0, refill_tag_we never asserted, counter=0.
- Spurious mem_rd_valid=1 and mem_wr_ack=1 while in IDLE with req_valid=0 -> no output change.
- Load miss immediately followed after REPLAY by a second load miss to 0x2000 -> a second mem_rd_req pulse with address 0x2000; counter restarts at 0.
